// File: rtl/qpi_sram_reader_if.sv
// rtl/qpi_sram_reader_if.sv - readback byte stream and SRAM pin group of qpi_sram_reader
interface qpi_sram_reader_if;
  logic [7:0] data;
  logic       data_valid;
  logic       data_ready;
  logic       sram_cs;
  logic       sram_clock;
  logic [3:0] sram_sio_tdo;
  logic [3:0] sram_sio_oe;
  logic [3:0] sram_sio_tdi;

  modport master (
    output data, data_valid, sram_cs, sram_clock, sram_sio_tdo, sram_sio_oe,
    input  data_ready, sram_sio_tdi
  );

  modport slave (
    input  data, data_valid, sram_cs, sram_clock, sram_sio_tdo, sram_sio_oe,
    output data_ready, sram_sio_tdi
  );
endinterface

// File: rtl/qpi_sram_reader.sv
// rtl/qpi_sram_reader.sv - QPI read master: cmd/addr/dummy header, nibble capture, byte stream out
// Optional CS-low segmentation is enabled with the SRAM_READ_CS_SPLIT_EN macro.
module qpi_sram_reader #(
  parameter logic [7:0] READ_CMD   = 8'h03,
  parameter int         DUMMY_CLKS = 2
`ifdef SRAM_READ_CS_SPLIT_EN
  ,
  parameter int         MAX_BURST  = 1024
`endif
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [23:0] start_addr,
  input  logic [15:0] length,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  qpi_sram_reader_if.master bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_DUMMY = 3'd3;
  localparam logic [2:0] S_READ  = 3'd4;
  localparam logic [2:0] S_CSHI  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;       // header nibble index, dummy period count, CSHI cycle count
  logic [15:0] rem_q, rem_d;       // bytes still to be read
  logic [23:0] addr_q, addr_d;     // address of the next byte to complete
  logic        lo_q, lo_d;         // 1 while the current READ period carries the low nibble
  logic [3:0]  hi_nib_q, hi_nib_d;
  logic        resume_q, resume_d; // CSHI is a segment break, not the end of the transfer
  logic        cs_q, cs_d;
  logic        sclk_q, sclk_d;
  logic [3:0]  tdo_q, tdo_d;
  logic [3:0]  oe_q, oe_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
`ifdef SRAM_READ_CS_SPLIT_EN
  logic [15:0] seg_q, seg_d;       // bytes completed in the current CS-low window
`endif

  // Nibble idx of the 8-nibble header {opcode, address}, most significant first.
  function automatic logic [3:0] hdr_nib(input logic [2:0] idx, input logic [23:0] a);
    logic [31:0] w;
    w = {READ_CMD, a} << {idx, 2'b00};
    return w[31:28];
  endfunction

  // Next-state, pin and stream logic; abort overrides everything outside IDLE/DONE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    addr_d   = addr_q;
    lo_d     = lo_q;
    hi_nib_d = hi_nib_q;
    resume_d = resume_q;
    cs_d     = cs_q;
    sclk_d   = sclk_q;
    tdo_d    = tdo_q;
    oe_d     = oe_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    data_d   = data_q;
    valid_d  = valid_q;
`ifdef SRAM_READ_CS_SPLIT_EN
    seg_d    = seg_q;
`endif

    if (valid_q && bus.data_ready) valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (length != 16'd0) begin
            state_d  = S_CMD;
            cs_d     = 1'b0;
            sclk_d   = 1'b0;
            oe_d     = 4'hF;
            tdo_d    = hdr_nib(3'd0, start_addr);
            cnt_d    = 8'd0;
            rem_d    = length;
            addr_d   = start_addr;
            lo_d     = 1'b0;
            resume_d = 1'b0;
            busy_d   = 1'b1;
`ifdef SRAM_READ_CS_SPLIT_EN
            seg_d    = 16'd0;
`endif
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end

      S_CMD, S_ADDR: begin
        if (!sclk_q) begin
          sclk_d = 1'b1;
        end else begin
          sclk_d = 1'b0;
          if (cnt_q == 8'd7) begin
            cnt_d   = 8'd0;
            oe_d    = 4'h0;
            tdo_d   = 4'h0;
            lo_d    = 1'b0;
            state_d = (DUMMY_CLKS == 0) ? S_READ : S_DUMMY;
          end else begin
            cnt_d = cnt_q + 8'd1;
            tdo_d = hdr_nib(cnt_q[2:0] + 3'd1, addr_q);
            if (cnt_q == 8'd1) state_d = S_ADDR;
          end
        end
      end

      S_DUMMY: begin
        if (!sclk_q) begin
          sclk_d = 1'b1;
        end else begin
          sclk_d = 1'b0;
          if (cnt_q == 8'(DUMMY_CLKS - 1)) begin
            cnt_d   = 8'd0;
            state_d = S_READ;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      S_READ: begin
        if (!sclk_q) begin
          // A new byte only starts when the output register is free or being drained.
          if (lo_q || !valid_q || bus.data_ready) sclk_d = 1'b1;
        end else begin
          sclk_d = 1'b0;
          if (!lo_q) begin
            hi_nib_d = bus.sram_sio_tdi;
            lo_d     = 1'b1;
          end else begin
            data_d  = {hi_nib_q, bus.sram_sio_tdi};
            valid_d = 1'b1;
            lo_d    = 1'b0;
            rem_d   = rem_q - 16'd1;
            addr_d  = addr_q + 24'd1;
            if (rem_q == 16'd1) begin
              state_d  = S_CSHI;
              cs_d     = 1'b1;
              cnt_d    = 8'd0;
              resume_d = 1'b0;
            end
`ifdef SRAM_READ_CS_SPLIT_EN
            else if (seg_q == 16'(MAX_BURST - 1)) begin
              seg_d    = 16'd0;
              state_d  = S_CSHI;
              cs_d     = 1'b1;
              cnt_d    = 8'd0;
              resume_d = 1'b1;
            end else begin
              seg_d = seg_q + 16'd1;
            end
`endif
          end
        end
      end

      S_CSHI: begin
        if (cnt_q == 8'd1) begin
          if (resume_q) begin
            state_d  = S_CMD;
            cs_d     = 1'b0;
            sclk_d   = 1'b0;
            oe_d     = 4'hF;
            tdo_d    = hdr_nib(3'd0, addr_q);
            cnt_d    = 8'd0;
            lo_d     = 1'b0;
            resume_d = 1'b0;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort: release the bus now, spend one cs-high cycle in CSHI, then DONE.
    if (abort && (state_q != S_IDLE) && (state_q != S_DONE)) begin
      state_d  = S_CSHI;
      cnt_d    = 8'd1;
      resume_d = 1'b0;
      cs_d     = 1'b1;
      sclk_d   = 1'b0;
      oe_d     = 4'h0;
      tdo_d    = 4'h0;
      valid_d  = 1'b0;
      lo_d     = 1'b0;
      done_d   = 1'b0;
      busy_d   = 1'b1;
    end
  end

  // State and output registers, asynchronously returned to the idle pin state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      rem_q    <= 16'd0;
      addr_q   <= 24'd0;
      lo_q     <= 1'b0;
      hi_nib_q <= 4'h0;
      resume_q <= 1'b0;
      cs_q     <= 1'b1;
      sclk_q   <= 1'b0;
      tdo_q    <= 4'h0;
      oe_q     <= 4'h0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
`ifdef SRAM_READ_CS_SPLIT_EN
      seg_q    <= 16'd0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      addr_q   <= addr_d;
      lo_q     <= lo_d;
      hi_nib_q <= hi_nib_d;
      resume_q <= resume_d;
      cs_q     <= cs_d;
      sclk_q   <= sclk_d;
      tdo_q    <= tdo_d;
      oe_q     <= oe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
`ifdef SRAM_READ_CS_SPLIT_EN
      seg_q    <= seg_d;
`endif
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign bus.data         = data_q;
  assign bus.data_valid   = valid_q;
  assign bus.sram_cs      = cs_q;
  assign bus.sram_clock   = sclk_q;
  assign bus.sram_sio_tdo = tdo_q;
  assign bus.sram_sio_oe  = oe_q;

endmodule

// File: tb/tb_qpi_sram_reader.sv
// tb/tb_qpi_sram_reader.sv - scoreboard bench for qpi_sram_reader with a QPI SRAM responder model
module tb_qpi_sram_reader;
  localparam int TB_DUMMY = 2;
`ifdef SRAM_READ_CS_SPLIT_EN
  localparam int TB_BURST = 4;
`else
  localparam int TB_BURST = 65536;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [23:0] start_addr = 24'd0;
  logic [15:0] length = 16'd0;
  logic        abort = 1'b0;
  logic        busy;
  logic        done;

  qpi_sram_reader_if bus();

`ifdef SRAM_READ_CS_SPLIT_EN
  qpi_sram_reader #(.READ_CMD(8'h03), .DUMMY_CLKS(TB_DUMMY), .MAX_BURST(TB_BURST)) dut (
`else
  qpi_sram_reader #(.READ_CMD(8'h03), .DUMMY_CLKS(TB_DUMMY)) dut (
`endif
    .clock(clock), .reset_n(reset_n), .start(start), .start_addr(start_addr),
    .length(length), .abort(abort), .busy(busy), .done(done), .bus(bus.master)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail = 0;
  logic [7:0]  exp_q[$];
  logic [23:0] exp_hdr_q[$];
  int done_cnt = 0, busy_cyc = 0, csh_cyc = 0, csl_cyc = 0, n_acc = 0;
  int sclk_edges = 0;
  int perr = 0;
  int ready_mode = 0;
  int d_base, csh_base, busy_base, sclk_base, csl_base;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // SRAM contents: two fixed bytes for the basic case, a scrambled function of address elsewhere.
  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    if (a == 24'h000010) return 8'hA5;
    if (a == 24'h000011) return 8'h3C;
    return (a[7:0] * 8'd37) ^ a[15:8] ^ {a[19:16], a[23:20]} ^ 8'h5A;
  endfunction

  always @(posedge bus.sram_clock) sclk_edges++;

  // Ready driver.
  initial begin
    bus.data_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
        0:       bus.data_ready = 1'b1;
        1:       bus.data_ready = 1'($urandom_range(0, 1));
        default: bus.data_ready = 1'b0;
      endcase
    end
  end

  // SRAM responder: decodes the header from the pins and returns memory nibbles.
  initial begin
    int edges;
    int k;
    logic [31:0] hdr;
    logic [7:0]  b;
    logic [23:0] eh;
    bus.sram_sio_tdi = 4'h0;
    forever begin
      @(negedge bus.sram_cs);
      edges = 0;
      hdr = 32'd0;
      while (bus.sram_cs === 1'b0) begin
        @(posedge bus.sram_clock or posedge bus.sram_cs);
        if (bus.sram_cs !== 1'b0) break;
        edges++;
        if (edges <= 8) begin
          if (bus.sram_sio_oe !== 4'hF) perr++;
          hdr = {hdr[27:0], bus.sram_sio_tdo};
          if (edges == 8) begin
            check("hdr_expected", exp_hdr_q.size() != 0, 1);
            eh = (exp_hdr_q.size() != 0) ? exp_hdr_q.pop_front() : 24'd0;
            check("hdr_cmd_addr", hdr, {8'h03, eh});
          end
        end else begin
          if (bus.sram_sio_oe !== 4'h0) perr++;
          if (edges > 8 + TB_DUMMY) begin
            k = edges - 9 - TB_DUMMY;
            b = mem_byte(hdr[23:0] + 24'(k / 2));
            #1;
            bus.sram_sio_tdi = (k % 2 == 0) ? b[7:4] : b[3:0];
          end
        end
      end
    end
  end

  // Monitor: counts pin activity and checks every accepted byte against the scoreboard.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clock);
      if (reset_n) begin
        if (done) done_cnt++;
        if (busy) busy_cyc++;
        if (busy && bus.sram_cs) csh_cyc++;
        if (!bus.sram_cs) csl_cyc++;
        if (bus.data_valid && bus.data_ready) begin
          n_acc++;
          check("byte_expected", exp_q.size() != 0, 1);
          e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
          check("byte_data", bus.data, e);
        end
      end
    end
  end

  task automatic start_xfer(input logic [23:0] a, input int len);
    for (int i = 0; i < len; i++) exp_q.push_back(mem_byte(a + 24'(i)));
    for (int k = 0; k < len; k += TB_BURST) exp_hdr_q.push_back(a + 24'(k));
    d_base = done_cnt; csh_base = csh_cyc; busy_base = busy_cyc;
    sclk_base = sclk_edges; csl_base = csl_cyc;
    @(posedge clock); #1;
    start = 1'b1; start_addr = a; length = 16'(len);
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clock);
      if (done_cnt > d_base) begin ok = 1'b1; return; end
    end
  endtask

  task automatic wait_acc(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clock);
      if (n_acc >= target) begin ok = 1'b1; return; end
    end
  endtask

  task automatic finish_xfer(input int segs);
    bit ok;
    wait_done(ok);
    check("done_seen", ok, 1);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clock);
    repeat (3) @(negedge clock);
    check("bytes_drained", exp_q.size(), 0);
    check("done_once", done_cnt - d_base, 1);
    check("cs_high_busy", csh_cyc - csh_base, 2 * segs);
    check("hdr_consumed", exp_hdr_q.size(), 0);
    check("pin_protocol", perr, 0);
  endtask

  function automatic int nsegs(input int len);
    return (len + TB_BURST - 1) / TB_BURST;
  endfunction

  initial begin
    bit ok;
    int len, a0;
    logic [23:0] a;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #3;
    check("reset_outputs",
          {bus.sram_cs, bus.sram_clock, bus.sram_sio_tdo, bus.sram_sio_oe, busy, done, bus.data, bus.data_valid},
          {1'b1, 20'd0});
    @(posedge clock); #1 reset_n = 1'b1;
    repeat (2) @(posedge clock);

    // Basic read.
    ready_mode = 0;
    start_xfer(24'h000010, 2);
    finish_xfer(1);

    // Backpressure: stall after the first byte.
    a = 24'($urandom);
    a0 = n_acc;
    start_xfer(a, 3);
    wait_acc(a0 + 1, ok);
    check("bp_first_byte", ok, 1);
    ready_mode = 2;
    repeat (14) @(negedge clock);
    sclk_base = sclk_edges;
    check("bp_data_pending", {bus.data_valid, bus.data}, {1'b1, mem_byte(a + 24'd1)});
    repeat (20) @(negedge clock);
    check("bp_no_sclk", sclk_edges - sclk_base, 0);
    check("bp_cs_sclk_low", {bus.sram_cs, bus.sram_clock}, 2'b00);
    check("bp_data_stable", {bus.data_valid, bus.data}, {1'b1, mem_byte(a + 24'd1)});
    ready_mode = 0;
    finish_xfer(1);

    // Zero length.
    start_xfer(24'($urandom), 0);
    finish_xfer(0);
    check("zero_busy", busy_cyc - busy_base, 0);
    check("zero_no_cs", csl_cyc - csl_base, 0);
    check("zero_no_sclk", sclk_edges - sclk_base, 0);

    // Abort after the first of four bytes.
    a0 = n_acc;
    start_xfer(24'($urandom), 4);
    wait_acc(a0 + 1, ok);
    check("abort_first_byte", ok, 1);
    @(posedge clock); #1 abort = 1'b1;
    @(posedge clock); #1 abort = 1'b0;
    check("abort_pins", {bus.sram_cs, bus.sram_clock, bus.sram_sio_oe, bus.data_valid}, 7'b1000000);
    exp_q.delete();
    sclk_base = sclk_edges;
    wait_done(ok);
    check("abort_done", ok, 1);
    repeat (20) @(negedge clock);
    check("abort_done_once", done_cnt - d_base, 1);
    check("abort_no_sclk", sclk_edges - sclk_base, 0);
    check("abort_no_bytes", n_acc - a0, 1);

    // Reset during the address phase.
    start_xfer(24'($urandom), 4);
    repeat (6) @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    check("reset_async",
          {bus.sram_cs, bus.sram_clock, bus.sram_sio_tdo, bus.sram_sio_oe, busy, done, bus.data, bus.data_valid},
          {1'b1, 20'd0});
    exp_q.delete();
    exp_hdr_q.delete();
    @(posedge clock); #1 reset_n = 1'b1;
    repeat (2) @(posedge clock);
    len = $urandom_range(1, 6);
    start_xfer(24'($urandom), len);
    finish_xfer(nsegs(len));

`ifdef SRAM_READ_CS_SPLIT_EN
    // Segmented transfer across the address wrap.
    start_xfer(24'hFFFFFE, 6);
    finish_xfer(2);
`endif

    // Randomized transfers with random backpressure.
    ready_mode = 1;
    for (int t = 0; t < 8; t++) begin
      len = $urandom_range(1, 10);
      start_xfer(24'($urandom), len);
      finish_xfer(nsegs(len));
    end
    ready_mode = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
